pry2oht_rr: RTL
===============

Name: pry2oht_rr

Overview:
Round-robin arbiter built on the rightmost-priority to one-hot tree. It takes a WIDTH-bit request vector and produces a one-hot grant plus its binary index. A handshake (vld/rdy) advances a registered rotating mask, so priority is fair across requesters. An optional lock mode holds a grant across several accepted transfers for multi-beat transactions. It sits in front of shared resources such as bus ports and FIFO write sides.

Parameters:
WIDTH, 32, number of requesters; power of SPLIT, at least 2.
SPLIT, 2, tree radix passed to the internal priority trees.
IMPLEMENTATION, 0, leaf implementation selector passed through to the trees.
LOCK_EN, 1, 1 enables the lck input and the LOCKED state; 0 ties lock behaviour off.
WIDTH_LOG, $clog2(WIDTH), localparam; width of idx.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
req  input  WIDTH  request vector; bit i is requester i.
lck  input  1  lock request, sampled only on a transfer; ignored when LOCK_EN=0.
oht  output  WIDTH  one-hot grant; all zeros when no grant.
idx  output  WIDTH_LOG  binary index of the oht bit; 0 when vld=0.
vld  output  1  grant valid.
rdy  input  1  consumer accepts the grant; a transfer occurs when vld and rdy are both high.

Behaviour:
- State: msk[WIDTH-1:0] (reset all ones); fsm in {ARB, LOCKED} (reset ARB); hld[WIDTH-1:0] held grant (reset 0).
- Reset values: in reset state with req=0, the outputs are oht=0, idx=0 and vld=0.
- All outputs are combinational from req and the registered state. Latency from req to grant is 0 cycles.
- ARB state:
  - Compute oht_m = pry2oht(req & msk) and oht_u = pry2oht(req). Rightmost (lowest index) wins.
  - oht = oht_m if (req & msk) is non-zero, else oht_u. vld = |req.
- LOCKED state:
  - oht = hld & req, vld = |(hld & req).
  - Other requests are ignored.
- Transfer in ARB with granted index g:
  - msk[j] becomes 1 for j>g and 0 otherwise.
  - g = WIDTH-1 wraps: msk becomes all ones.
  - If lck=1 and LOCK_EN=1: hld <= oht and fsm goes to LOCKED. The mask still updates at the same edge.
- Transfer in LOCKED:
  - lck=1: stay LOCKED.
  - lck=0: go to ARB and clear hld.
  - msk is unchanged in LOCKED.
- Held requester drops: if (hld & req)==0 while LOCKED, go to ARB next edge and clear hld. No transfer occurs that cycle (vld=0).
- No transfer (vld=0 or rdy=0): msk, fsm and hld hold. The grant may change if req changes; the consumer is responsible for req stability if it needs it.
- rdy while vld=0: no effect.
- rst has priority over every other update. Reset mid-lock returns to ARB with msk all ones.
- idx is the binary encode of oht (OR-reduction per bit). It is guaranteed consistent with oht in the same cycle.

Decomposition:
- Package pry2oht_pkg holds:
  - the fsm enum (ARB, LOCKED);
  - a function oht2bin(WIDTH) shared with other blocks.
- Two instances of the existing pry2oht_tree, masked and unmasked, with the same SPLIT and IMPLEMENTATION.
- The mask-update logic is inline. No further sub-module.

Test Plan (WIDTH=8, LOCK_EN=1):
- Reset, then req=0 -> oht=0, idx=0, vld=0 for 3 cycles; msk=8'hFF.
- req=8'h0F held, rdy=1 for 5 cycles -> idx sequence 0,1,2,3,0; vld=1 every cycle.
- req=8'h81, rdy=1 -> grants alternate bit 0 and bit 7 (idx 0,7,0,7). This exercises the wrap from index 7 back to msk=8'hFF.
- req=8'h06, rdy=0 for 4 cycles, then rdy=1 -> idx stays 1 while stalled, and is 2 on the cycle after the first transfer.
- req=8'h0C with lck=1 on the first transfer (idx=2):
  - next 3 transfers with lck=1 -> idx stays 2;
  - transfer with lck=0 -> fsm returns to ARB and the next grant is idx=3.
- LOCKED on idx=2, then req changes to 8'h08 -> vld=0 for one cycle, fsm goes to ARB, then idx=3, vld=1.
- Assert rst mid-LOCKED with req=8'hFF -> after reset, idx=0.

Source files
------------

// File: rtl/pry2oht_pkg.sv
// Shared types and helpers for the rightmost-priority one-hot arbiter family.
package pry2oht_pkg;

    typedef enum logic {
        ARB,
        LOCKED
    } fsm_t;

    // Widest one-hot vector oht2bin accepts; callers zero-extend narrower vectors.
    localparam int OHT_MAX_W = 256;
    localparam int BIN_W     = 8;

    // OR of the indices of every set bit; exact for a one-hot or all-zero input.
    function automatic logic [BIN_W-1:0] oht2bin(input logic [OHT_MAX_W-1:0] oht);
        logic [BIN_W-1:0] bin;
        bin = '0;
        for (int i = 0; i < OHT_MAX_W; i++) begin
            if (oht[i]) begin
                bin = bin | BIN_W'(i);
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/pry2oht_tree.sv
// Rightmost (lowest index) priority to one-hot, built as a radix-SPLIT tree of small leaves.
module pry2oht_tree #(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] oht,
    output logic             vld
);

    generate
        if (WIDTH <= SPLIT) begin : g_leaf
            assign vld = |req;
            if (IMPLEMENTATION == 0) begin : g_arith
                // Two's-complement trick isolates the lowest set bit.
                assign oht = req & (~req + WIDTH'(1));
            end else begin : g_scan
                always_comb begin
                    oht = '0;
                    for (int i = WIDTH - 1; i >= 0; i--) begin
                        if (req[i]) begin
                            oht = WIDTH'(1) << i;
                        end
                    end
                end
            end
        end else begin : g_node
            localparam int SUB = WIDTH / SPLIT;

            logic [SPLIT-1:0] grp_vld;
            logic [SPLIT-1:0] grp_sel;
            logic [WIDTH-1:0] sub_oht;
            logic             top_vld;

            for (genvar g = 0; g < SPLIT; g++) begin : g_sub
                pry2oht_tree #(
                    .WIDTH         (SUB),
                    .SPLIT         (SPLIT),
                    .IMPLEMENTATION(IMPLEMENTATION)
                ) u_sub (
                    .req(req[g*SUB +: SUB]),
                    .oht(sub_oht[g*SUB +: SUB]),
                    .vld(grp_vld[g])
                );
                assign oht[g*SUB +: SUB] = sub_oht[g*SUB +: SUB] & {SUB{grp_sel[g]}};
            end

            // The lowest non-empty group wins, then its local winner is passed through.
            pry2oht_tree #(
                .WIDTH         (SPLIT),
                .SPLIT         (SPLIT),
                .IMPLEMENTATION(IMPLEMENTATION)
            ) u_top (
                .req(grp_vld),
                .oht(grp_sel),
                .vld(top_vld)
            );

            assign vld = top_vld;
        end
    endgenerate

endmodule

// File: rtl/pry2oht_rr.sv
// Round-robin arbiter: masked/unmasked priority trees, a rotating mask advanced on each
// accepted grant, and an optional lock that pins one requester across multiple beats.
module pry2oht_rr
    import pry2oht_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0,
    parameter int LOCK_EN        = 1,
    localparam int WIDTH_LOG     = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     req,
    input  logic                 lck,
    output logic [WIDTH-1:0]     oht,
    output logic [WIDTH_LOG-1:0] idx,
    output logic                 vld,
    input  logic                 rdy
);

    fsm_t             fsm;
    logic [WIDTH-1:0] msk;
    logic [WIDTH-1:0] hld;

    logic [WIDTH-1:0] req_m;
    logic [WIDTH-1:0] oht_m;
    logic [WIDTH-1:0] oht_u;
    logic [WIDTH-1:0] hld_req;
    logic [WIDTH-1:0] msk_nxt;
    logic             vld_m;
    logic             vld_u;
    logic             xfer;
    logic             lock_on;

    assign req_m   = req & msk;
    assign hld_req = hld & req;

    pry2oht_tree #(
        .WIDTH         (WIDTH),
        .SPLIT         (SPLIT),
        .IMPLEMENTATION(IMPLEMENTATION)
    ) u_tree_m (
        .req(req_m),
        .oht(oht_m),
        .vld(vld_m)
    );

    pry2oht_tree #(
        .WIDTH         (WIDTH),
        .SPLIT         (SPLIT),
        .IMPLEMENTATION(IMPLEMENTATION)
    ) u_tree_u (
        .req(req),
        .oht(oht_u),
        .vld(vld_u)
    );

    always_comb begin
        if (fsm == LOCKED) begin
            oht = hld_req;
            vld = |hld_req;
        end else begin
            oht = vld_m ? oht_m : oht_u;
            vld = vld_u;
        end
    end

    assign idx     = WIDTH_LOG'(oht2bin(OHT_MAX_W'(oht)));
    assign xfer    = vld & rdy;
    assign lock_on = (LOCK_EN != 0) && lck;

    // Keep only requesters strictly above the winner; a win at the top bit reopens everyone.
    assign msk_nxt = oht[WIDTH-1] ? '1 : ~(oht | (oht - WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            msk <= '1;
            hld <= '0;
            fsm <= ARB;
        end else begin
            case (fsm)
                ARB: begin
                    if (xfer) begin
                        msk <= msk_nxt;
                        if (lock_on) begin
                            hld <= oht;
                            fsm <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (!vld || (rdy && !lock_on)) begin
                        hld <= '0;
                        fsm <= ARB;
                    end
                end
                default: begin
                    hld <= '0;
                    fsm <= ARB;
                end
            endcase
        end
    end

endmodule
